// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port between two writeback
//            requesters (0 = ALU, 1 = load / multi-cycle unit). Each requester
//            owns a one-entry holding buffer with a valid/ready handshake. One
//            buffered write is granted per cycle into a registered output stage
//            that drives the register file. Pending-write flags let the hazard
//            logic stall reads of registers that have not been written yet.
// Ports    : clock, reset             - rising-edge clock, async active-high reset
//            reqN_valid/ready/reg/data - requester N handshake and write payload
//            reg_write, write_register, write_data - registered write port
//            read_register_1/2        - source indices being decoded
//            pending_1/2              - source index has a write in flight
//            conflict                 - pulse: both buffers held same nonzero index
// Config   : REGFILE_ARB_RR_EN defined   -> round-robin on ties
//            REGFILE_ARB_RR_EN undefined -> requester 0 always wins ties
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        reg_write,
  output logic [4:0]  write_register,
  output logic [31:0] write_data,
  input  logic [4:0]  read_register_1,
  input  logic [4:0]  read_register_2,
  output logic        pending_1,
  output logic        pending_2,
  output logic        conflict
);

  localparam logic [4:0] c_zero_reg = 5'd0;

  // Holding buffers
  logic        r_buf_valid_0;
  logic [4:0]  r_buf_reg_0;
  logic [31:0] r_buf_data_0;
  logic        r_buf_valid_1;
  logic [4:0]  r_buf_reg_1;
  logic [31:0] r_buf_data_1;

  // Output stage and arbitration history
  logic        r_reg_write;
  logic [4:0]  r_write_register;
  logic [31:0] r_write_data;
  logic        r_conflict;
  logic        r_last_grant;

  logic        w_tie_to_0;
  logic        w_grant_0;
  logic        w_grant_1;
  logic        w_any_grant;
  logic        w_load_0;
  logic        w_load_1;
  logic        w_same_reg;
  logic [4:0]  w_win_reg;
  logic [31:0] w_win_data;

`ifdef REGFILE_ARB_RR_EN
  // last_grant == 1 means requester 1 went last, so requester 0 takes the tie.
  assign w_tie_to_0 = r_last_grant;
`else
  // Fixed priority: requester 0 always takes the tie. The pointer is folded in
  // only so it stays a live register; it never changes the decision.
  assign w_tie_to_0 = r_last_grant | 1'b1;
`endif

  assign w_grant_0   = r_buf_valid_0 && (!r_buf_valid_1 || w_tie_to_0);
  assign w_grant_1   = r_buf_valid_1 && !w_grant_0;
  assign w_any_grant = w_grant_0 || w_grant_1;

  // Ready depends only on buffer state, so a granted buffer can reload on the
  // same edge and a single requester sustains one write per cycle.
  assign req0_ready = !r_buf_valid_0 || w_grant_0;
  assign req1_ready = !r_buf_valid_1 || w_grant_1;
  assign w_load_0   = req0_valid && req0_ready;
  assign w_load_1   = req1_valid && req1_ready;

  assign w_win_reg  = w_grant_1 ? r_buf_reg_1  : r_buf_reg_0;
  assign w_win_data = w_grant_1 ? r_buf_data_1 : r_buf_data_0;

  // Both buffers valid always implies a grant this cycle.
  assign w_same_reg = r_buf_valid_0 && r_buf_valid_1 &&
                      (r_buf_reg_0 == r_buf_reg_1) && (r_buf_reg_0 != c_zero_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf_valid_0 <= 1'b0;
      r_buf_reg_0   <= 5'd0;
      r_buf_data_0  <= 32'd0;
      r_buf_valid_1 <= 1'b0;
      r_buf_reg_1   <= 5'd0;
      r_buf_data_1  <= 32'd0;
    end else begin
      if (w_load_0) begin
        r_buf_valid_0 <= 1'b1;
        r_buf_reg_0   <= req0_reg;
        r_buf_data_0  <= req0_data;
      end else if (w_grant_0) begin
        r_buf_valid_0 <= 1'b0;
      end
      if (w_load_1) begin
        r_buf_valid_1 <= 1'b1;
        r_buf_reg_1   <= req1_reg;
        r_buf_data_1  <= req1_data;
      end else if (w_grant_1) begin
        r_buf_valid_1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg_write      <= 1'b0;
      r_write_register <= 5'd0;
      r_write_data     <= 32'd0;
      r_conflict       <= 1'b0;
      r_last_grant     <= 1'b1;
    end else begin
      r_conflict <= w_same_reg;
      if (w_any_grant) begin
        // A write to $zero is consumed here but never reaches the file.
        r_reg_write      <= (w_win_reg != c_zero_reg);
        r_write_register <= w_win_reg;
        r_write_data     <= w_win_data;
        r_last_grant     <= w_grant_1;
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  assign reg_write      = r_reg_write;
  assign write_register = r_write_register;
  assign write_data     = r_write_data;
  assign conflict       = r_conflict;

  function automatic logic in_flight(input logic [4:0] idx);
    in_flight = (idx != c_zero_reg) &&
                ((r_buf_valid_0 && (r_buf_reg_0 == idx)) ||
                 (r_buf_valid_1 && (r_buf_reg_1 == idx)) ||
                 (r_reg_write   && (r_write_register == idx)));
  endfunction

  assign pending_1 = in_flight(read_register_1);
  assign pending_2 = in_flight(read_register_2);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter. A behavioural model
//            of the two buffers, grant rule and write port predicts every output
//            each cycle; a shadow register file fed by the model is compared
//            against one fed by the DUT's write port. Build with the same
//            REGFILE_ARB_RR_EN setting as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_reg = 5'd0, req1_reg = 5'd0;
  logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  read_register_1 = 5'd0, read_register_2 = 5'd0;
  logic        pending_1, pending_2;
  logic        conflict;

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_reg       (req0_reg),
    .req0_data      (req0_data),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_reg       (req1_reg),
    .req1_data      (req1_data),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .read_register_1(read_register_1),
    .read_register_2(read_register_2),
    .pending_1      (pending_1),
    .pending_2      (pending_2),
    .conflict       (conflict)
  );

  // Register file driven by the DUT's write port
  logic [31:0] dut_rf [32];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) dut_rf[i] <= 32'd0;
    end else if (reg_write) begin
      dut_rf[write_register] <= write_data;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_bv [2];
  logic [4:0]  m_br [2];
  logic [31:0] m_bd [2];
  logic        m_last, m_we, m_conf;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic [31:0] exp_rf [32];
  logic        acc0, acc1;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bv[i] = 1'b0; m_br[i] = 5'd0; m_bd[i] = 32'd0;
    end
    m_last = 1'b1; m_we = 1'b0; m_conf = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
  endtask

  // Which buffer is written this cycle (-1: none)
  function automatic int winner();
    if (m_bv[0] && m_bv[1]) begin
`ifdef REGFILE_ARB_RR_EN
      return (m_last == 1'b1) ? 0 : 1;
`else
      return 0;
`endif
    end
    if (m_bv[0]) return 0;
    if (m_bv[1]) return 1;
    return -1;
  endfunction

  function automatic logic m_pending(input logic [4:0] r);
    return (r != 5'd0) && ((m_bv[0] && m_br[0] == r) || (m_bv[1] && m_br[1] == r) ||
                           (m_we && m_wr == r));
  endfunction

  // One clock: check combinational outputs, advance the model, cross the edge,
  // check registered outputs. Entered and left at posedge+1.
  task automatic tick();
    int   w;
    logic rdy0, rdy1;
    #1;
    w    = winner();
    rdy0 = !m_bv[0] || (w == 0);
    rdy1 = !m_bv[1] || (w == 1);
    check("req0_ready", req0_ready, rdy0);
    check("req1_ready", req1_ready, rdy1);
    check("pending_1", pending_1, m_pending(read_register_1));
    check("pending_2", pending_2, m_pending(read_register_2));
    acc0   = req0_valid && rdy0;
    acc1   = req1_valid && rdy1;
    m_conf = m_bv[0] && m_bv[1] && (m_br[0] == m_br[1]) && (m_br[0] != 5'd0);
    if (w >= 0) begin
      m_wr   = m_br[w];
      m_wd   = m_bd[w];
      m_we   = (m_wr != 5'd0);
      m_last = (w == 1);
      if (m_we) exp_rf[m_wr] = m_wd;
      m_bv[w] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (acc0) begin m_bv[0] = 1'b1; m_br[0] = req0_reg; m_bd[0] = req0_data; end
    if (acc1) begin m_bv[1] = 1'b1; m_br[1] = req1_reg; m_bd[1] = req1_data; end
    @(posedge clock);
    #1;
    check("reg_write", reg_write, m_we);
    check("write_register", write_register, m_wr);
    check("write_data", write_data, m_wd);
    check("conflict", conflict, m_conf);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Asynchronous reset pulse starting mid-cycle; returns at posedge+1.
  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_reg_write", reg_write, 1'b0);
    check("rst_write_register", write_register, 5'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_conflict", conflict, 1'b0);
    check("rst_req0_ready", req0_ready, 1'b1);
    check("rst_req1_ready", req1_ready, 1'b1);
    check("rst_pending_1", pending_1, 1'b0);
    check("rst_pending_2", pending_2, 1'b0);
    idle_inputs();
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0] order [$];
    logic [4:0] exp_order [8];
    int i0, i1, conf_count, run, max_run;

    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // Reset mid-transfer with both buffers full and a write in the output stage
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'h99;
    tick();
    tick();
    read_register_1 = 5'd3; read_register_2 = 5'd9;
    do_reset();
    tick();
    check("no_stale_write", reg_write, 1'b0);

    // Single uncontended write
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h10;
    read_register_1 = 5'd5; read_register_2 = 5'd0;
    tick();
    idle_inputs();
    tick();
    check("single_we", reg_write, 1'b1);
    check("single_reg", write_register, 5'd5);
    check("single_data", write_data, 32'h10);
    tick();
    tick();

    // Write to $zero
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hDEADBEEF;
    read_register_1 = 5'd0; read_register_2 = 5'd0;
    tick();
    idle_inputs();
    tick();
    check("zero_we", reg_write, 1'b0);
    tick();

    // Tie: both requesters continuously valid
    do_reset();
`ifdef REGFILE_ARB_RR_EN
    exp_order = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
`else
    exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 5'd12, 5'd13, 5'd14};
`endif
    i0 = 0; i1 = 0;
    for (int c = 0; c < 20; c++) begin
      req0_valid = (i0 < 4); req0_reg = 5'(1 + i0);  req0_data = 32'(100 + i0);
      req1_valid = (i1 < 4); req1_reg = 5'(11 + i1); req1_data = 32'(200 + i1);
      tick();
      if (acc0) i0++;
      if (acc1) i1++;
      if (reg_write) order.push_back(write_register);
    end
    idle_inputs();
    check("tie_count", order.size(), 8);
    for (int k = 0; k < 8 && k < order.size(); k++) check("tie_order", order[k], exp_order[k]);

    // Same-register conflict
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h1;
    req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h2;
    conf_count = 0;
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (conflict) conf_count++;
    end
    check("conflict_pulses", conf_count, 1);
    check("conflict_final_r7", dut_rf[7], 32'h2);

    // Back-to-back writes from requester 0
    run = 0; max_run = 0;
    for (int i = 0; i < 34; i++) begin
      req0_valid = (i < 32);
      req0_reg   = 5'((i % 31) + 1);
      req0_data  = 32'(3 * i + 1);
      tick();
      if (reg_write) run++; else run = 0;
      if (run > max_run) max_run = run;
    end
    idle_inputs();
    check("b2b_run", max_run, 32);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_reg   = 5'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_reg   = 5'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      read_register_1 = 5'($urandom_range(0, 7));
      read_register_2 = 5'($urandom_range(0, 7));
      acc0 = 1'b0; acc1 = 1'b0;
      tick();
    end
    idle_inputs();
    tick();
    tick();
    tick();
    for (int r = 0; r < 32; r++) check("regfile_contents", dut_rf[r], exp_rf[r]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32 register file (`reg_write`, `write_register`, `write_data`) between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load / multi-cycle unit writeback). Each requester has a one-entry holding buffer with a valid/ready handshake. The block grants one buffered write per cycle into a registered output stage that drives the register file directly. It also reports pending writes to the hazard logic, so a read of a not-yet-written register can be stalled.

## Interface
- No parameters. Widths are fixed: 5-bit register index, 32-bit data.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a write.
- `req0_ready`  out  1  requester 0 write accepted this edge when valid.
- `req0_reg`  in  5  destination index.
- `req0_data`  in  32  write value.
- `req1_valid`, `req1_ready`, `req1_reg`, `req1_data`: same as requester 0, for requester 1.
- `reg_write`  out  1  registered write enable to the register file.
- `write_register`  out  5  registered destination index.
- `write_data`  out  32  registered write value.
- `read_register_1`, `read_register_2`  in  5  source indices being decoded.
- `pending_1`, `pending_2`  out  1  combinational: the source index has a write in flight.
- `conflict`  out  1  registered one-cycle pulse: both buffers held the same nonzero index when a grant was made.

## Operation
- **Buffer i.** Fields are `buf_valid_i`, `buf_reg_i`, `buf_data_i`.
  - `reqi_ready = !buf_valid_i || grant_i`. Buffer i loads on the edge where `reqi_valid && reqi_ready`.
  - `buf_valid_i` clears when granted and not reloaded on the same edge.
- **Grant.** Evaluated combinationally from the buffer valids. At most one grant per cycle.
  - One valid buffer: it wins.
  - Both valid: arbitration is set by the Configuration macro.
- **Output stage (every edge).**
  - On a grant: `write_register`/`write_data` load the winner's fields, and `reg_write` loads `(winner_reg != 0)`.
  - A write to $zero is consumed but never asserts `reg_write`.
  - No grant: `reg_write` loads 0. `write_register`/`write_data` hold their values.
- **`last_grant` pointer (1 bit).** Updates to the granted requester on every grant.
- **`pending_k`** is high when `read_register_k != 0` and it equals either:
  - `buf_reg_0` with `buf_valid_0`, or
  - `buf_reg_1` with `buf_valid_1`, or
  - `write_register` with `reg_write`.
- **`conflict`** is set to 1 on an edge where both buffers are valid, `buf_reg_0 == buf_reg_1 != 0` and a grant occurs; 0 otherwise. The final register value follows grant order. Cross-requester ordering is not guaranteed; the pipeline must avoid it.
- **Reset (asynchronous, any time, including mid-transfer).**
  - Buffers invalid, `reg_write=0`, `write_register=0`, `write_data=0`, `conflict=0`, `last_grant=1` (requester 0 wins the first tie).
  - In-flight writes are discarded.
  - Derived outputs while reset is held: `req0_ready=req1_ready=1`, `pending_1=pending_2=0`.

## Timing
- **Uncontended latency.** Accept at edge N. Grant at edge N+1, where `reg_write` rises. The register file writes at edge N+2.
- **Throughput.** One write per cycle in total. A requester that wins every cycle sustains one write per cycle, because the buffer reloads on the same edge it is granted.
- **Loser behaviour.** The losing buffer holds and its `ready` is low until it is granted. Its requester must hold valid/reg/data stable while `ready` is low.
- **Combinational paths.**
  - `ready` depends on the buffer valid state only, never on `reqi_valid`.
  - `pending_*` is combinational from `read_register_*` and registered state.

## Configuration
- **`REGFILE_ARB_RR_EN` defined:** round-robin on ties. The winner is the requester other than `last_grant`. A requester waits at most 1 cycle behind the other.
- **`REGFILE_ARB_RR_EN` undefined:** fixed priority, requester 0 always wins ties. Requester 1 can starve while requester 0 is continuously valid. `last_grant` is still maintained but unused.

## Test plan
- **Reset.** Assert reset mid-transfer with both buffers full → all outputs are 0 immediately, both `ready` are 1, and after release no stale write appears.
- **Single write.** req0 writes r5=0x00000010 at edge N → `reg_write=1`, `write_register=5`, `write_data=0x10` during cycle N+1; `pending_1=1` for `read_register_1=5` from N to N+2.
- **Zero register.** req1 writes r0=0xDEADBEEF → accepted, `reg_write` stays 0, `pending_*` stays 0 for index 0.
- **Tie, RR build.** Both requesters continuously valid, r1..r4 on req0 and r11..r14 on req1 → output order is r1, r11, r2, r12, ...
- **Tie, fixed build.** Same stimulus → r1..r4 first, then r11..r14.
- **Conflict.** Both requesters write r7 in the same cycle (0x1 on req0, 0x2 on req1) → `conflict` pulses once; the final r7 value matches the grant order (RR build: 0x2).
- **Back-to-back.** req0 valid for 32 cycles writing ri=3i+1 → 32 consecutive `reg_write` cycles with no bubble and `req0_ready` always 1.
